shift_add_multiplier: RTL and testbench

- Sequential N x N unsigned multiplier using the shift-and-add method, with one N-bit ripple adder reused every cycle.
- Sits directly around the adder stage: it feeds the adder its operands each cycle and consumes the N+1-bit sum/carry result.
- Operands arrive and the 2N-bit product leaves over valid/ready handshakes.

---
 rtl/shift_add_multiplier_pkg.sv | 14 +
 rtl/shift_add_multiplier_adder.sv | 23 ++
 rtl/shift_add_multiplier.sv | 113 +++++++++++
 tb/tb_shift_add_multiplier.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_e;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// N-bit ripple-carry adder with bit-per-element unpacked ports.
module n_bit_adder #(
   parameter int N = 4
) (
   input  logic a_i [N],
   input  logic b_i [N],
   input  logic c_i,
   output logic s_o [N],
   output logic c_o
);

   logic c [N+1];

   assign c[0] = c_i;

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign c_o = c[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential N x N unsigned shift-and-add multiplier around one reused ripple adder.
// Optional early termination when the remaining multiplier bits are zero: SHIFT_ADD_MULT_EARLY_TERM_EN.
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [N-1:0]   a_i,
   input  logic [N-1:0]   b_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [2*N-1:0] prod_o,
   output logic           busy_o
);

   localparam int CW = cnt_width(N);

   mult_state_e   state_q, state_d;
   logic [N-1:0]  mcand_q, mcand_d;
   logic [N-1:0]  hi_q, hi_d;
   logic [N-1:0]  lo_q, lo_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          add_a [N];
   logic          add_b [N];
   logic          add_s [N];
   logic          add_c;
   logic [N-1:0]  sum;

   // Adder sees hi and the multiplicand gated by the current multiplier LSB.
   for (genvar i = 0; i < N; i++) begin : g_bridge
      assign add_a[i] = hi_q[i];
      assign add_b[i] = mcand_q[i] & lo_q[0];
      assign sum[i]   = add_s[i];
   end

   n_bit_adder #(.N(N)) u_adder (
      .a_i (add_a),
      .b_i (add_b),
      .c_i (1'b0),
      .s_o (add_s),
      .c_o (add_c)
   );

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
   logic [N-1:0] rem_mask;
   assign rem_mask = ~({N{1'b1}} << cnt_q);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               mcand_d = a_i;
               hi_d    = '0;
               lo_d    = b_i;
               cnt_d   = CW'(N);
               state_d = RUN;
            end
         end
         RUN: begin
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
            if ((lo_q & rem_mask) == '0) begin
               {hi_d, lo_d} = {hi_q, lo_q} >> cnt_q;
               cnt_d        = '0;
               state_d      = DONE;
            end else
`endif
            begin
               // Carry out of the adder becomes the new product MSB.
               {hi_d, lo_d} = {add_c, sum, lo_q[N-1:1]};
               cnt_d        = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready_o  = (state_q == IDLE);
   assign busy_o      = (state_q == RUN);
   assign out_valid_o = (state_q == DONE);
   assign prod_o      = {hi_q, lo_q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (N=4) against a plain-arithmetic reference.
module tb_shift_add_multiplier;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b1;
   logic [N-1:0]   a = '0;
   logic [N-1:0]   b = '0;
   logic           in_ready;
   logic           out_valid;
   logic           busy;
   logic [2*N-1:0] prod;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   shift_add_multiplier #(.N(N)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .prod_o      (prod),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Edges from the accept edge (inclusive) up to the edge after which out_valid is seen.
   function automatic int exp_lat(input int bv);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
      int msb;
      if (bv == 0) return 2;
      msb = 0;
      for (int i = 0; i < N; i++) if ((bv >> i) & 1) msb = i;
      if (msb == N - 1) return N + 1;
      return msb + 3;
`else
      return N + 1;
`endif
   endfunction

   task automatic do_op(input int av, input int bv, input int hold);
      int lat;
      logic [2*N-1:0] held;
      chk("in_ready_before_accept", in_ready, 1);
      a = av[N-1:0];
      b = bv[N-1:0];
      in_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("busy_after_accept", busy, (exp_lat(bv) > 2 || N == 1) ? 1 : 1);
      chk("in_ready_in_run", in_ready, 0);
      lat = 1;
      while (!out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, exp_lat(bv));
      chk("product", prod, (av * bv) & ((1 << (2 * N)) - 1));
      held = prod;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("bp_prod_stable", prod, held);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("out_valid_dropped", out_valid, 0);
      chk("back_to_idle", in_ready, 1);
   endtask

   initial begin
      int acc [3];
      int pa [3];
      int pb [3];
      int ir_cnt;
      int guard;

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_prod", prod, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed products including carry path and zero operands
      do_op(13, 11, 0);
      do_op(15, 15, 0);
      do_op(0, 9, 0);
      do_op(7, 0, 0);

      // Backpressure
      do_op(6, 5, 10);

      // Back-to-back with in_valid held high
      pa = '{3, 9, 15};
      pb = '{4, 9, 1};
      ir_cnt = 0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = pa[i][N-1:0];
         b = pb[i][N-1:0];
         guard = 0;
         while (!in_ready && guard < 32) begin
            @(posedge clk); #1;
            guard++;
         end
         chk("b2b_accept_seen", in_ready, 1);
         ir_cnt++;
         acc[i] = cyc;
         @(posedge clk); #1;
         if (i == 2) in_valid = 1'b0;
         guard = 0;
         while (!out_valid && guard < 32) begin
            if (in_ready) ir_cnt++;
            @(posedge clk); #1;
            guard++;
         end
         chk("b2b_product", prod, pa[i] * pb[i]);
      end
      chk("b2b_interval_0", acc[1] - acc[0], N + 2);
      chk("b2b_interval_1", acc[2] - acc[1], N + 2);
      chk("b2b_in_ready_pulses", ir_cnt, 3);
      @(posedge clk); #1;
      chk("b2b_idle", in_ready, 1);

      // Reset in the middle of a run
      a = 4'd12;
      b = 4'd12;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_prod", prod, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(2, 3, 0);

      // Randomized operands and backpressure
      for (int i = 0; i < 16; i++) begin
         int ra, rb, rh;
         ra = int'($urandom_range(0, (1 << N) - 1));
         rb = int'($urandom_range(0, (1 << N) - 1));
         rh = int'($urandom_range(0, 3));
         do_op(ra, rb, rh);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
